// File: rtl/conv_pool_stage_pkg.sv
// Shared fp32 constants, field widths and FSM encoding for the conv_pool_stage
// ReLU + max-pool block.
package conv_pool_stage_pkg;

  localparam int FP_SIGN_W = 1;
  localparam int FP_EXP_W  = 8;
  localparam int FP_MAN_W  = 23;
  localparam int FP_W      = FP_SIGN_W + FP_EXP_W + FP_MAN_W;

  localparam logic [FP_W-1:0] FP32_ZERO = 32'h0000_0000;
  localparam logic [FP_W-1:0] FP32_QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE,
    EVEN_ROW,
    ODD_ROW,
    FINISH
  } state_t;

  function automatic logic fp32_is_nan(input logic [FP_W-1:0] v);
    return (&v[FP_MAN_W +: FP_EXP_W]) && (|v[FP_MAN_W-1:0]);
  endfunction

endpackage

// File: rtl/fp32_max2.sv
// Combinational fp32 max by sign-magnitude; signed zeros tie and a tie keeps
// operand a, any NaN input yields the canonical quiet NaN.
module fp32_max2
  import conv_pool_stage_pkg::*;
(
  input  logic [FP_W-1:0] a_i,
  input  logic [FP_W-1:0] b_i,
  output logic [FP_W-1:0] max_o
);

  localparam int MAG_W = FP_EXP_W + FP_MAN_W;

  logic             a_sign, b_sign, b_wins;
  logic [MAG_W-1:0] a_mag, b_mag;

  assign a_sign = a_i[FP_W-1];
  assign b_sign = b_i[FP_W-1];
  assign a_mag  = a_i[MAG_W-1:0];
  assign b_mag  = b_i[MAG_W-1:0];

  always_comb begin
    b_wins = 1'b0;
    if (a_mag == '0 && b_mag == '0) begin
      b_wins = 1'b0;
    end else if (a_sign != b_sign) begin
      b_wins = a_sign;
    end else if (!a_sign) begin
      b_wins = (b_mag > a_mag);
    end else begin
      b_wins = (b_mag < a_mag);
    end
  end

  assign max_o = (fp32_is_nan(a_i) || fp32_is_nan(b_i)) ? FP32_QNAN
               : (b_wins ? b_i : a_i);

endmodule

// File: rtl/conv_pool_stage.sv
// ReLU + 2x2 stride-2 max pooling over a row-major fp32 matrix stream.
// Even rows fold column pairs into a half-width line buffer; odd rows finish each window.
module conv_pool_stage
  import conv_pool_stage_pkg::*;
#(
  parameter int MAX_N   = 64,
  parameter bit RELU_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [7:0]      in_size,
  input  logic            in_valid,
  input  logic [FP_W-1:0] in_data,
  output logic            out_valid,
  output logic [FP_W-1:0] out_data,
  output logic [7:0]      out_size,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int         BUF_D   = MAX_N / 2;
  localparam int         BUF_AW  = (BUF_D > 1) ? $clog2(BUF_D) : 1;
  localparam logic [7:0] MAX_N_B = 8'(MAX_N);

  state_t            state_q;
  logic [7:0]        n_q, row_q, col_q;
  logic [FP_W-1:0]   a_q, c_q;
  logic [FP_W-1:0]   line_buf_q [BUF_D];
  logic [FP_W-1:0]   elem, buf_rd, pair_max, buf_c_max, quad_max;
  logic [BUF_AW-1:0] buf_idx;
  logic              accept, last_col, last_row, size_ok;

  assign elem     = (RELU_EN && in_data[FP_W-1]) ? FP32_ZERO : in_data;
  assign accept   = in_valid && (state_q == EVEN_ROW || state_q == ODD_ROW);
  assign last_col = (col_q == n_q - 8'd1);
  assign last_row = (row_q == n_q - 8'd1);
  assign size_ok  = (in_size >= 8'd2) && (in_size <= MAX_N_B);
  assign buf_idx  = col_q[BUF_AW:1];
  assign buf_rd   = line_buf_q[buf_idx];

  fp32_max2 u_max_pair (.a_i(a_q),       .b_i(elem), .max_o(pair_max));
  fp32_max2 u_max_bufc (.a_i(buf_rd),    .b_i(c_q),  .max_o(buf_c_max));
  fp32_max2 u_max_quad (.a_i(buf_c_max), .b_i(elem), .max_o(quad_max));

  always_ff @(posedge clk) begin
    if (accept && state_q == EVEN_ROW && col_q[0]) begin
      line_buf_q[buf_idx] <= pair_max;
    end
  end

  // IDLE wait start | EVEN_ROW fold pairs | ODD_ROW emit windows | FINISH done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      n_q       <= '0;
      row_q     <= '0;
      col_q     <= '0;
      a_q       <= FP32_ZERO;
      c_q       <= FP32_ZERO;
      out_valid <= 1'b0;
      out_data  <= FP32_ZERO;
      out_size  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            n_q      <= in_size;
            out_size <= in_size >> 1;
            busy     <= 1'b1;
            row_q    <= '0;
            col_q    <= '0;
            err      <= (in_size > MAX_N_B);
            state_q  <= size_ok ? EVEN_ROW : FINISH;
          end
        end
        EVEN_ROW, ODD_ROW: begin
          if (in_valid) begin
            if (!col_q[0]) begin
              if (state_q == EVEN_ROW) a_q <= elem;
              else                     c_q <= elem;
            end else if (state_q == ODD_ROW) begin
              out_valid <= 1'b1;
              out_data  <= quad_max;
            end
            if (last_col) begin
              col_q <= '0;
              row_q <= row_q + 8'd1;
              if (last_row)                   state_q <= FINISH;
              else if (state_q == EVEN_ROW)   state_q <= ODD_ROW;
              else                            state_q <= EVEN_ROW;
            end else begin
              col_q <= col_q + 8'd1;
            end
          end
        end
        FINISH: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_pool_stage.sv
// Scoreboard bench for conv_pool_stage: two instances (ReLU on / off) share one
// stimulus stream; expected pooled words and done cycles are queued by the driver.
module tb_conv_pool_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, in_valid;
  logic [7:0]  in_size;
  logic [31:0] in_data;
  logic [1:0]  ov, bz, dn, er;
  logic [31:0] od [2];
  logic [7:0]  os [2];

  conv_pool_stage #(.MAX_N(64), .RELU_EN(1'b1)) u_dut_relu (
    .clk(clk), .rst(rst), .start(start), .in_size(in_size), .in_valid(in_valid),
    .in_data(in_data), .out_valid(ov[0]), .out_data(od[0]), .out_size(os[0]),
    .busy(bz[0]), .done(dn[0]), .err(er[0]));

  conv_pool_stage #(.MAX_N(64), .RELU_EN(1'b0)) u_dut_lin (
    .clk(clk), .rst(rst), .start(start), .in_size(in_size), .in_valid(in_valid),
    .in_data(in_data), .out_valid(ov[1]), .out_data(od[1]), .out_size(os[1]),
    .busy(bz[1]), .done(dn[1]), .err(er[1]));

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        out_q  [2][$];
  int          done_q [2][$];
  logic [31:0] vals_q [$];
  logic [31:0] mat    [2][4096];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: fp32 ordering via a signed integer key on sign-magnitude.
  function automatic bit ref_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'h0);
  endfunction

  function automatic longint ref_key(input logic [31:0] v);
    longint mag;
    mag = longint'(v[30:0]);
    return v[31] ? -mag : mag;
  endfunction

  function automatic logic [31:0] ref_relu(input logic [31:0] v, input bit en);
    return (en && v[31]) ? 32'h0 : v;
  endfunction

  function automatic logic [31:0] ref_pool(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c, input logic [31:0] d);
    logic [31:0] q [4];
    logic [31:0] best;
    q = '{a, b, c, d};
    for (int i = 0; i < 4; i++) if (ref_nan(q[i])) return 32'h7FC0_0000;
    best = q[0];
    for (int i = 1; i < 4; i++) if (ref_key(q[i]) > ref_key(best)) best = q[i];
    return best;
  endfunction

  function automatic logic [31:0] int2fp(input int k);
    int          p;
    logic [31:0] m;
    p = 0;
    while ((k >> (p + 1)) != 0) p++;
    m = 32'(k) << (23 - p);
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 11))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'h7F80_0000;
      3:       return 32'hFF80_0000;
      4:       return {r[31], 8'h00, r[22:0]};
      5:       return ($urandom_range(0, 3) == 0) ? 32'h7FA0_0001 : {r[31], 8'h7F, 23'h0};
      default: return {r[31], 8'h7C + {5'd0, r[2:0]}, r[22:21], 21'h0};
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (ov[d] === 1'b1) begin
        if (out_q[d].size() == 0) begin
          chk($sformatf("unexpected_out_dut%0d", d), 64'd1, 64'd0);
        end else begin
          e = out_q[d].pop_front();
          chk($sformatf("out_data_dut%0d", d), 64'(od[d]), 64'(e.data));
          chk($sformatf("out_cycle_dut%0d", d), 64'(cyc), 64'(e.cyc));
        end
      end
      if (dn[d] === 1'b1) begin
        if (done_q[d].size() == 0) begin
          chk($sformatf("unexpected_done_dut%0d", d), 64'd1, 64'd0);
        end else begin
          chk($sformatf("done_cycle_dut%0d", d), 64'(cyc), 64'(done_q[d].pop_front()));
        end
      end
    end
  end

  task automatic load_ints();
    vals_q.delete();
    for (int k = 1; k <= 16; k++) vals_q.push_back(int2fp(k));
  endtask

  task automatic load_fill(input int cnt, input logic [31:0] v);
    vals_q.delete();
    for (int k = 0; k < cnt; k++) vals_q.push_back(v);
  endtask

  task automatic wait_done(input int n);
    int budget;
    budget = 0;
    while ((done_q[0].size() != 0 || done_q[1].size() != 0) && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    chk("done_pending", 64'(done_q[0].size() + done_q[1].size()), 64'd0);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("out_pending_dut%0d", d), 64'(out_q[d].size()), 64'd0);
      chk($sformatf("busy_after_dut%0d", d), 64'(bz[d]), 64'd0);
      chk($sformatf("size_after_dut%0d", d), 64'(os[d]), 64'(8'(n) >> 1));
      chk($sformatf("err_sticky_dut%0d", d), 64'(er[d]), 64'(n > 64));
    end
  endtask

  // gap_mode: 0 gapless, 1 valid toggles every cycle, 2 random bubbles.
  task automatic run_frame(input int n, input int gap_mode, input int abort_after,
                           input int stray_at);
    int          s_edge, e, r, c, half, gaps;
    logic [31:0] v;
    exp_t        x;
    half  = n / 2;
    start = 1'b1;
    in_size = 8'(n);
    @(posedge clk); #1;
    start   = 1'b0;
    in_size = 8'($urandom);
    s_edge  = cyc;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("busy_start_dut%0d", d), 64'(bz[d]), 64'd1);
      chk($sformatf("size_start_dut%0d", d), 64'(os[d]), 64'(8'(n) >> 1));
      chk($sformatf("err_start_dut%0d", d), 64'(er[d]), 64'(n > 64));
    end
    if (n < 2 || n > 64) begin
      for (int d = 0; d < 2; d++) done_q[d].push_back(s_edge + 1);
    end else begin
      for (int i = 0; i < n * n; i++) begin
        if (i == abort_after) break;
        gaps = 0;
        if (gap_mode == 1 && i > 0) gaps = 1;
        if (gap_mode == 2 && $urandom_range(0, 3) == 0) gaps = $urandom_range(1, 3);
        repeat (gaps) begin
          in_valid = 1'b0;
          in_data  = $urandom;
          @(posedge clk); #1;
        end
        v        = vals_q[i];
        in_valid = 1'b1;
        in_data  = v;
        if (i == stray_at) begin
          start   = 1'b1;
          in_size = 8'd1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        start    = 1'b0;
        e = cyc;
        r = i / n;
        c = i % n;
        for (int d = 0; d < 2; d++) mat[d][i] = ref_relu(v, d == 0);
        if (r % 2 == 1 && c % 2 == 1 && r < 2 * half && c < 2 * half) begin
          for (int d = 0; d < 2; d++) begin
            x.data = ref_pool(mat[d][i-n-1], mat[d][i-n], mat[d][i-1], mat[d][i]);
            x.cyc  = e;
            out_q[d].push_back(x);
          end
        end
        if (i == n * n - 1) for (int d = 0; d < 2; d++) done_q[d].push_back(e + 1);
      end
    end
    if (abort_after >= 0) begin
      rst = 1'b1;
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("abort_valid_dut%0d", d), 64'(ov[d]), 64'd0);
        chk($sformatf("abort_busy_dut%0d", d), 64'(bz[d]), 64'd0);
        chk($sformatf("abort_size_dut%0d", d), 64'(os[d]), 64'd0);
        chk($sformatf("abort_pending_dut%0d", d), 64'(out_q[d].size()), 64'd0);
      end
      rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
    end else begin
      wait_done(n);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run did not complete (%0d/%0d so far)", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_size = 8'd0; in_data = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_valid_dut%0d", d), 64'(ov[d]), 64'd0);
      chk($sformatf("rst_data_dut%0d", d), 64'(od[d]), 64'd0);
      chk($sformatf("rst_size_dut%0d", d), 64'(os[d]), 64'd0);
      chk($sformatf("rst_busy_dut%0d", d), 64'(bz[d]), 64'd0);
      chk($sformatf("rst_done_dut%0d", d), 64'(dn[d]), 64'd0);
      chk($sformatf("rst_err_dut%0d", d), 64'(er[d]), 64'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    vals_q.delete();
    for (int k = 0; k < 9; k++)
      vals_q.push_back(k < 3 ? 32'h411C_0000 : (k < 6 ? 32'h4134_0000 : 32'h414C_0000));
    run_frame(3, 0, -1, -1);

    load_ints();  run_frame(4, 0, -1, -1);
    load_ints();  run_frame(4, 1, -1, -1);
    load_ints();  run_frame(4, 0, -1, 7);
    load_fill(4, 32'hC020_0000);  run_frame(2, 0, -1, -1);
    vals_q = '{32'h8000_0000, 32'h0000_0000, 32'hBF80_0000, 32'hC040_0000};
    run_frame(2, 0, -1, -1);
    vals_q = '{32'h3F80_0000, 32'h7FC0_0001, 32'h4000_0000, 32'h4040_0000};
    run_frame(2, 0, -1, -1);

    run_frame(1, 0, -1, -1);
    run_frame(0, 0, -1, -1);
    run_frame(100, 0, -1, -1);
    run_frame(65, 0, -1, -1);

    load_ints();  run_frame(4, 0, 6, -1);
    load_ints();  run_frame(4, 2, -1, -1);

    vals_q.delete();
    for (int k = 0; k < 64 * 64; k++) vals_q.push_back(rand_fp());
    run_frame(64, 0, -1, -1);

    for (int f = 0; f < 12; f++) begin
      n = $urandom_range(2, 9);
      vals_q.delete();
      for (int k = 0; k < n * n; k++) vals_q.push_back(rand_fp());
      run_frame(n, $urandom_range(0, 2), -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
